// File: rtl/regfile_wb.sv
// Write-back register file: two combinational read ports with write-through
// bypass, one write port, a saturating committed-write counter and a record
// of the last written address. Register 0 is hard-wired to zero.
module regfile_wb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              WE3,
  input  logic [ADDR_W-1:0] A3,
  input  logic [DATA_W-1:0] WD3,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic [15:0]       wr_count,
  output logic [ADDR_W-1:0] last_A3
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [15:0]       wr_count_q, wr_count_d;
  logic [ADDR_W-1:0] last_a3_q, last_a3_d;
  logic              commit;

  // A write only takes effect outside reset and never to register 0; the
  // same qualifier gates the bypass so reset also suppresses forwarding.
  assign commit = WE3 && (A3 != '0) && !reset;

  // Next-state for the register array, counter and last-address record.
  always_comb begin
    regs_d     = regs_q;
    wr_count_d = wr_count_q;
    last_a3_d  = last_a3_q;
    if (commit) begin
      regs_d[A3] = WD3;
      last_a3_d  = A3;
      if (wr_count_q != 16'hFFFF) begin
        wr_count_d = wr_count_q + 16'd1;
      end
    end
  end

  // State registers with synchronous reset taking priority over writes.
  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      wr_count_q <= '0;
      last_a3_q  <= '0;
    end else begin
      regs_q     <= regs_d;
      wr_count_q <= wr_count_d;
      last_a3_q  <= last_a3_d;
    end
  end

  // Read port 1: zero for r0, write-through when the port hits the write.
  always_comb begin
    RD1 = regs_q[A1];
    if (A1 == '0) begin
      RD1 = '0;
    end else if (commit && (A1 == A3)) begin
      RD1 = WD3;
    end
  end

  // Read port 2: identical rule, so both ports agree on a shared address.
  always_comb begin
    RD2 = regs_q[A2];
    if (A2 == '0) begin
      RD2 = '0;
    end else if (commit && (A2 == A3)) begin
      RD2 = WD3;
    end
  end

  assign wr_count = wr_count_q;
  assign last_A3  = last_a3_q;

endmodule

// File: tb/tb_regfile_wb.sv
// Bench for regfile_wb: directed vectors with literal expectations plus a
// reference model checked against the outputs on every falling edge.
module tb_regfile_wb;

  logic        CLK = 1'b0;
  logic        reset;
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic [15:0] wr_count;
  logic [4:0]  last_A3;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [31:0] m_mem [32];
  int          m_cnt;
  int          m_last;
  bit          m_valid = 1'b0;

  regfile_wb dut (
    .CLK(CLK), .reset(reset), .WE3(WE3), .A3(A3), .WD3(WD3),
    .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
    .wr_count(wr_count), .last_A3(last_A3)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected read value: r0 is zero, a live write to the same address forwards.
  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (WE3 && A3 != 5'd0 && !reset && a == A3) return WD3;
    return m_mem[a];
  endfunction

  // Model update on each rising edge.
  always @(posedge CLK) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;
      m_cnt  = 0;
      m_last = 0;
    end else if (WE3 && A3 != 5'd0) begin
      m_mem[A3] = WD3;
      m_last    = A3;
      m_cnt     = (m_cnt < 65535) ? m_cnt + 1 : 65535;
    end
  end

  // Compare process: outputs against the model in mid-cycle.
  always @(negedge CLK) begin
    if (m_valid) begin
      chk("cmp_rd1", {32'd0, RD1}, {32'd0, exp_rd(A1)});
      chk("cmp_rd2", {32'd0, RD2}, {32'd0, exp_rd(A2)});
      chk("cmp_cnt", {48'd0, wr_count}, 64'(m_cnt));
      chk("cmp_last", {59'd0, last_A3}, 64'(m_last));
    end
  end

  task automatic drive(input logic rst, input logic we, input logic [4:0] a3,
                       input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2);
    reset = rst; WE3 = we; A3 = a3; WD3 = wd; A1 = a1; A2 = a2;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic mid();
    @(negedge CLK);
    #1;
  endtask

  initial begin
    drive(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    step();
    step();
    m_valid = 1'b1;

    // Reset state
    drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd1, 5'd31);
    mid();
    chk("rst_rd1", {32'd0, RD1}, 64'd0);
    chk("rst_rd2", {32'd0, RD2}, 64'd0);
    chk("rst_cnt", {48'd0, wr_count}, 64'd0);
    chk("rst_last", {59'd0, last_A3}, 64'd0);
    step();

    // Plain write then read
    drive(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd1, 5'd2);
    step();
    drive(1'b0, 1'b0, 5'd5, 32'd0, 5'd5, 5'd0);
    mid();
    chk("wr5_rd1", {32'd0, RD1}, 64'hDEADBEEF);
    chk("wr5_cnt", {48'd0, wr_count}, 64'd1);
    chk("wr5_last", {59'd0, last_A3}, 64'd5);
    step();

    // Same-cycle bypass on both ports
    drive(1'b0, 1'b1, 5'd7, 32'h12345678, 5'd7, 5'd7);
    mid();
    chk("byp_rd1", {32'd0, RD1}, 64'h12345678);
    chk("byp_rd2", {32'd0, RD2}, 64'h12345678);
    step();
    drive(1'b0, 1'b0, 5'd7, 32'd0, 5'd7, 5'd7);
    mid();
    chk("byp_store", {32'd0, RD1}, 64'h12345678);
    chk("byp_cnt", {48'd0, wr_count}, 64'd2);
    step();

    // Write to r0 is discarded and never forwarded
    drive(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    mid();
    chk("r0_byp", {32'd0, RD1}, 64'd0);
    step();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd7);
    mid();
    chk("r0_rd", {32'd0, RD1}, 64'd0);
    chk("r0_cnt", {48'd0, wr_count}, 64'd2);
    chk("r0_last", {59'd0, last_A3}, 64'd7);
    step();

    // WE3=0 must not forward
    drive(1'b0, 1'b0, 5'd9, 32'h99999999, 5'd9, 5'd9);
    mid();
    chk("nowe_rd1", {32'd0, RD1}, 64'd0);
    step();

    // Back-to-back writes, later one wins
    drive(1'b0, 1'b1, 5'd10, 32'h11111111, 5'd0, 5'd0);
    step();
    drive(1'b0, 1'b1, 5'd10, 32'h22222222, 5'd0, 5'd0);
    step();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd10, 5'd5);
    mid();
    chk("b2b_rd1", {32'd0, RD1}, 64'h22222222);
    chk("b2b_cnt", {48'd0, wr_count}, 64'd4);
    step();

    // Bypass on port 2 only while port 1 reads stored data
    drive(1'b0, 1'b1, 5'd10, 32'h33333333, 5'd5, 5'd10);
    mid();
    chk("p2byp_rd1", {32'd0, RD1}, 64'hDEADBEEF);
    chk("p2byp_rd2", {32'd0, RD2}, 64'h33333333);
    step();

    // Reset beats a simultaneous write; no forwarding during reset
    drive(1'b0, 1'b1, 5'd3, 32'h0F0F0F0F, 5'd0, 5'd0);
    step();
    drive(1'b1, 1'b1, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd3);
    mid();
    chk("rstw_nobyp", {32'd0, RD1}, 64'h0F0F0F0F);
    step();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd5);
    mid();
    chk("rstw_r3", {32'd0, RD1}, 64'd0);
    chk("rstw_r5", {32'd0, RD2}, 64'd0);
    chk("rstw_cnt", {48'd0, wr_count}, 64'd0);
    chk("rstw_last", {59'd0, last_A3}, 64'd0);
    step();

    // First write after reset commits
    drive(1'b0, 1'b1, 5'd4, 32'hCAFEF00D, 5'd0, 5'd0);
    step();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd4, 5'd0);
    mid();
    chk("post_rd", {32'd0, RD1}, 64'hCAFEF00D);
    chk("post_cnt", {48'd0, wr_count}, 64'd1);
    step();

    // Saturation: 65537 further committed writes
    for (int i = 0; i <= 65536; i++) begin
      drive(1'b0, 1'b1, 5'((i % 31) + 1), 32'(i), 5'd0, 5'd0);
      step();
    end
    drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd4);
    mid();
    chk("sat_cnt", {48'd0, wr_count}, 64'hFFFF);
    chk("sat_last", {59'd0, last_A3}, 64'd3);
    chk("sat_rd", {32'd0, RD1}, 64'h00010000);
    step();
    drive(1'b0, 1'b1, 5'd20, 32'h55AA55AA, 5'd0, 5'd0);
    step();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd20, 5'd0);
    mid();
    chk("sat_hold", {48'd0, wr_count}, 64'hFFFF);
    chk("sat_last2", {59'd0, last_A3}, 64'd20);
    chk("sat_rd2", {32'd0, RD1}, 64'h55AA55AA);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb.md
REGFILE_WB -- requirements
Module: regfile_wb

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the register width in bits.
REQ-002 Parameter ADDR_W, default 5, SHALL set the address width; register count SHALL be 2**ADDR_W.
REQ-003 CLK  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be the synchronous, active-high reset, sampled on the rising edge of CLK.
REQ-005 WE3  input  1  SHALL be the write enable for the write-back port.
REQ-006 A3  input  ADDR_W  SHALL be the write-back destination register address.
REQ-007 WD3  input  DATA_W  SHALL be the write-back data, driven from the registered write-data stage.
REQ-008 A1  input  ADDR_W  SHALL be the read port 1 address.
REQ-009 A2  input  ADDR_W  SHALL be the read port 2 address.
REQ-010 RD1  output  DATA_W  SHALL be the read port 1 data.
REQ-011 RD2  output  DATA_W  SHALL be the read port 2 data.
REQ-012 wr_count  output  16  SHALL be the saturating count of committed writes.
REQ-013 last_A3  output  ADDR_W  SHALL be the address of the most recent committed write.

Function
REQ-014 A write SHALL commit on the rising CLK edge when WE3=1, A3!=0 and reset=0: reg[A3] <= WD3.
REQ-015 Register 0 SHALL always read 0; writes to A3=0 SHALL be discarded and SHALL NOT count as committed.
REQ-016 Reads SHALL be combinational: RD1=reg[A1] and RD2=reg[A2] in the same cycle, with zero latency.
REQ-017 Write-through bypass: when WE3=1, A3!=0 and A1==A3, RD1 SHALL equal WD3 in that same cycle; the same rule SHALL apply to RD2 with A2.
REQ-018 The bypass SHALL be suppressed while reset=1; RD1 and RD2 SHALL then follow the stored contents.
REQ-019 When both read ports address the same register, both outputs SHALL return the same value, including under bypass.
REQ-020 wr_count SHALL increment by 1 on each committed write and SHALL hold at 16'hFFFF, with no wrap-around.
REQ-021 last_A3 SHALL load A3 on each committed write and SHALL otherwise hold.
REQ-022 WE3=1 with an X-free A3 outside the committed-write conditions SHALL leave all state unchanged.
REQ-023 Back-to-back writes to the same address SHALL each commit in order; the later value SHALL win.

Reset
REQ-024 reset=1 at a rising CLK edge SHALL clear every register, wr_count and last_A3 to 0.
REQ-025 Reset SHALL take priority over a simultaneous write; that write SHALL be lost and SHALL NOT be counted.
REQ-026 After reset deasserts, the first edge with WE3=1 and A3!=0 SHALL commit normally.

Verification
REQ-027 Reset, then read A1=1 and A2=31 -> RD1=0, RD2=0, wr_count=0, last_A3=0.
REQ-028 Write WE3=1, A3=5, WD3=32'hDEADBEEF, then the next cycle A1=5 with WE3=0 -> RD1=32'hDEADBEEF, wr_count=1, last_A3=5.
REQ-029 Same-cycle bypass: WE3=1, A3=7, WD3=32'h12345678, A1=A2=7 -> RD1=RD2=32'h12345678 before the edge; stored value matches after the edge.
REQ-030 Write WE3=1, A3=0, WD3=32'hFFFFFFFF, then A1=0 -> RD1=0, wr_count unchanged, no bypass in the write cycle.
REQ-031 Assert reset together with WE3=1, A3=3, WD3=32'hA5A5A5A5 -> reg[3]=0 and wr_count=0 after the edge.
REQ-032 Perform 65537 committed writes -> wr_count=16'hFFFF and holds; last_A3 equals the final A3.
